// File: rtl/bg_block_mem_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : bg_block_mem_sched_if
// Description : VRAM block read/write handshake between the BG scheduler and
//               the memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface bg_block_mem_sched_if;
    logic        o_memWriteReq;
    logic [14:0] o_memWriteAdr;
    logic [15:0] o_memWriteMsk;
    logic        i_memWriteAck;
    logic        o_memReadReq;
    logic [14:0] o_memReadAdr;
    logic        i_memReadAck;

    modport master (
        output o_memWriteReq, o_memWriteAdr, o_memWriteMsk, o_memReadReq, o_memReadAdr,
        input  i_memWriteAck, i_memReadAck
    );

    modport slave (
        input  o_memWriteReq, o_memWriteAdr, o_memWriteMsk, o_memReadReq, o_memReadAdr,
        output i_memWriteAck, i_memReadAck
    );
endinterface
`default_nettype wire

// File: rtl/bg_block_mem_sched.sv
`default_nettype none
// ============================================================================
// Module      : bg_block_mem_sched
// Description : Freezes the pixel pipeline around BG block save/load traffic
//               to VRAM and keeps save/load statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module bg_block_mem_sched #(
    parameter int CNT_W = 16
) (
    input  wire                   clk,
    input  wire                   i_rst,
    input  wire                   i_blockOp,
    input  wire  [1:0]            i_pairCode,
    input  wire                   i_noblend,
    input  wire  [14:0]           i_loadAdr,
    input  wire  [14:0]           i_saveAdr,
    input  wire  [15:0]           i_mskBlock,
    output logic                  o_pausePipeline,
    output logic                  o_resetSpike,
    output logic                  o_resetMask,
    output logic                  o_importBG,
    output logic                  o_flushDone,
    output logic                  o_busy,
    output logic [CNT_W-1:0]      o_saveCount,
    output logic [CNT_W-1:0]      o_loadCount,
    bg_block_mem_sched_if.master  mem
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAVE    = 2'd1,
        ST_LOAD    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam logic [1:0]       c_codeFirst = 2'b01;
    localparam logic [1:0]       c_codeNext  = 2'b10;
    localparam logic [1:0]       c_codeFlush = 2'b11;
    localparam logic [CNT_W-1:0] c_cntOne    = CNT_W'(1);

    state_t             r_state;
    state_t             w_next;
    logic [1:0]         r_code;
    logic               r_noblend;
    logic [14:0]        r_saveAdr;
    logic [14:0]        r_loadAdr;
    logic [15:0]        r_saveMsk;
    logic [CNT_W-1:0]   r_saveCount;
    logic [CNT_W-1:0]   r_loadCount;
    logic               w_trigger;
    logic               w_saveDone;
    logic               w_loadDone;

    assign w_trigger  = (r_state == ST_IDLE) && i_blockOp && (i_pairCode != 2'b00);
    assign w_saveDone = (r_state == ST_SAVE) && mem.i_memWriteAck;
    assign w_loadDone = (r_state == ST_LOAD) && mem.i_memReadAck;

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_code      <= 2'b00;
            r_noblend   <= 1'b0;
            r_saveAdr   <= 15'd0;
            r_loadAdr   <= 15'd0;
            r_saveMsk   <= 16'd0;
            r_saveCount <= '0;
            r_loadCount <= '0;
        end else begin
            r_state <= w_next;
            if (w_trigger) begin
                r_code    <= i_pairCode;
                r_noblend <= i_noblend;
                r_saveAdr <= i_saveAdr;
                r_loadAdr <= i_loadAdr;
                r_saveMsk <= i_mskBlock;
            end
            if (w_saveDone) begin
                r_saveCount <= r_saveCount + c_cntOne;
            end
            if (w_loadDone) begin
                r_loadCount <= r_loadCount + c_cntOne;
            end
        end
    end

    // IDLE decisions use live inputs because the latches only settle at the trigger edge.
    always_comb begin
        w_next       = r_state;
        o_resetSpike = 1'b0;
        o_resetMask  = 1'b0;
        o_importBG   = 1'b0;
        o_flushDone  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_trigger) begin
                    if (i_pairCode == c_codeFirst) begin
                        w_next = i_noblend ? ST_RELEASE : ST_LOAD;
                    end else if (i_mskBlock != 16'd0) begin
                        w_next = ST_SAVE;
                    end else if ((i_pairCode == c_codeNext) && !i_noblend) begin
                        w_next = ST_LOAD;
                    end else begin
                        w_next = ST_RELEASE;
                    end
                end
            end
            ST_SAVE: begin
                if (mem.i_memWriteAck) begin
                    w_next = ((r_code == c_codeNext) && !r_noblend) ? ST_LOAD : ST_RELEASE;
                end
            end
            ST_LOAD: begin
                if (mem.i_memReadAck) begin
                    o_importBG = 1'b1;
                    w_next     = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                o_resetSpike = 1'b1;
                o_resetMask  = 1'b1;
                o_flushDone  = (r_code == c_codeFlush);
                w_next       = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Pause rises combinationally in the trigger cycle so no pixel is written there.
    assign o_pausePipeline   = w_trigger || (r_state != ST_IDLE);
    assign o_busy            = (r_state != ST_IDLE);
    assign o_saveCount       = r_saveCount;
    assign o_loadCount       = r_loadCount;
    assign mem.o_memWriteReq = (r_state == ST_SAVE);
    assign mem.o_memWriteAdr = r_saveAdr;
    assign mem.o_memWriteMsk = r_saveMsk;
    assign mem.o_memReadReq  = (r_state == ST_LOAD);
    assign mem.o_memReadAdr  = r_loadAdr;

endmodule
`default_nettype wire

// File: tb/tb_bg_block_mem_sched.sv
`default_nettype none
// Bench for bg_block_mem_sched: directed scenarios plus randomized block
// operations checked against an outcome model (save?/load?/pause length).
module tb_bg_block_mem_sched;

    localparam int CNT_W   = 2;
    localparam int CNT_MOD = 1 << CNT_W;

    logic             clk = 1'b0;
    logic             i_rst = 1'b1;
    logic             i_blockOp = 1'b0;
    logic [1:0]       i_pairCode = 2'b00;
    logic             i_noblend = 1'b0;
    logic [14:0]      i_loadAdr = 15'd0;
    logic [14:0]      i_saveAdr = 15'd0;
    logic [15:0]      i_mskBlock = 16'd0;
    logic             o_pausePipeline, o_resetSpike, o_resetMask, o_importBG;
    logic             o_flushDone, o_busy;
    logic [CNT_W-1:0] o_saveCount, o_loadCount;

    bg_block_mem_sched_if memIf ();

    bg_block_mem_sched #(.CNT_W(CNT_W)) dut (
        .clk             (clk),
        .i_rst           (i_rst),
        .i_blockOp       (i_blockOp),
        .i_pairCode      (i_pairCode),
        .i_noblend       (i_noblend),
        .i_loadAdr       (i_loadAdr),
        .i_saveAdr       (i_saveAdr),
        .i_mskBlock      (i_mskBlock),
        .o_pausePipeline (o_pausePipeline),
        .o_resetSpike    (o_resetSpike),
        .o_resetMask     (o_resetMask),
        .o_importBG      (o_importBG),
        .o_flushDone     (o_flushDone),
        .o_busy          (o_busy),
        .o_saveCount     (o_saveCount),
        .o_loadCount     (o_loadCount),
        .mem             (memIf.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int expSave = 0;
    int expLoad = 0;

    // Observations of the most recent block operation
    int obsPause, obsW, obsR, obsImport, obsImportBad, obsSpike, obsMask, obsFlush;
    int obsRelCyc, obsFlushCyc, obsAdrBad, obsTimeout, obsLastW, obsFirstR;

    function automatic bit mdl_save(input logic [1:0] code, input logic [15:0] msk);
        return (code != 2'b01) && (msk != 16'd0);
    endfunction

    function automatic bit mdl_load(input logic [1:0] code, input logic nb);
        return (code != 2'b11) && !nb;
    endfunction

    function automatic logic [63:0] all_outputs();
        return {o_pausePipeline, o_resetSpike, o_resetMask, o_importBG, o_flushDone, o_busy,
                memIf.o_memWriteReq, memIf.o_memReadReq, memIf.o_memWriteAdr,
                memIf.o_memWriteMsk, memIf.o_memReadAdr, o_saveCount, o_loadCount};
    endfunction

    // Acts as backend and memory: holds blockOp until resetSpike, acks after the given latencies.
    task automatic run_op(input logic [1:0] pCode, input logic [15:0] pMsk, input logic pNb,
                          input logic [14:0] pSa, input logic [14:0] pLa,
                          input int pWl, input int pRl, input bit pScr, input bit pStray);
        int wCnt = 0;
        int rCnt = 0;
        bit done = 0;
        bit relSeen = 0;
        obsPause = 0; obsW = 0; obsR = 0; obsImport = 0; obsImportBad = 0;
        obsSpike = 0; obsMask = 0; obsFlush = 0; obsRelCyc = -1; obsFlushCyc = -1;
        obsAdrBad = 0; obsTimeout = 0; obsLastW = -1; obsFirstR = -1;
        @(negedge clk);
        i_blockOp = 1'b1; i_pairCode = pCode; i_mskBlock = pMsk; i_noblend = pNb;
        i_saveAdr = pSa; i_loadAdr = pLa;
        for (int c = 0; c < 64 && !done; c++) begin
            if (c > 0) @(negedge clk);
            memIf.i_memWriteAck = 1'b0;
            memIf.i_memReadAck  = 1'b0;
            if (relSeen) i_blockOp = 1'b0;
            if (c > 0 && pScr) begin
                i_pairCode = 2'($urandom); i_mskBlock = 16'($urandom); i_noblend = 1'($urandom);
                i_saveAdr = 15'($urandom); i_loadAdr = 15'($urandom);
            end
            #1;
            if (memIf.o_memWriteReq) begin
                wCnt++; obsW++; obsLastW = c;
                if (memIf.o_memWriteAdr !== pSa || memIf.o_memWriteMsk !== pMsk) obsAdrBad = 1;
                if (wCnt == pWl) memIf.i_memWriteAck = 1'b1;
                else if (pStray) memIf.i_memReadAck = 1'b1;
            end
            if (memIf.o_memReadReq) begin
                rCnt++; obsR++;
                if (obsFirstR < 0) obsFirstR = c;
                if (memIf.o_memReadAdr !== pLa) obsAdrBad = 1;
                if (rCnt == pRl) memIf.i_memReadAck = 1'b1;
            end
            #1;
            if (o_importBG) begin
                obsImport++;
                if (!memIf.o_memReadReq || !memIf.i_memReadAck) obsImportBad = 1;
            end
            if (o_resetSpike) begin obsSpike++; obsRelCyc = c; relSeen = 1; end
            if (o_resetMask) obsMask++;
            if (o_flushDone) begin obsFlush++; obsFlushCyc = c; end
            if (o_pausePipeline) obsPause++;
            else done = 1;
        end
        if (!done) obsTimeout = 1;
        @(negedge clk);
        memIf.i_memWriteAck = 1'b0;
        memIf.i_memReadAck  = 1'b0;
        i_blockOp = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_blockOp = 1'b0;
        i_rst = 1'b1;
        repeat (2) @(negedge clk);
        i_rst = 1'b0;
        expSave = 0;
        expLoad = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (all_outputs() !== 64'd0) begin
            errors++; $display("FAIL reset_state outputs got %h need 0", all_outputs());
        end
        i_rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (o_busy !== 1'b0 || o_pausePipeline !== 1'b0) begin
            errors++; $display("FAIL reset_release busy %b pause %b need 0 0", o_busy, o_pausePipeline);
        end
    endtask

    task automatic test_first_block();
        run_op(2'b01, 16'h0000, 1'b0, 15'h0AAA, 15'h1234, 1, 3, 0, 0);
        expLoad++;
        checks++;
        if (obsPause !== 5 || obsW !== 0 || obsR !== 3) begin
            errors++; $display("FAIL first_block pause/w/r got %0d/%0d/%0d need 5/0/3", obsPause, obsW, obsR);
        end
        checks++;
        if (obsImport !== 1 || obsImportBad !== 0 || obsAdrBad !== 0) begin
            errors++; $display("FAIL first_block import %0d bad %0d adrbad %0d need 1 0 0", obsImport, obsImportBad, obsAdrBad);
        end
        checks++;
        if (obsRelCyc !== 4 || obsSpike !== 1 || obsMask !== 1 || obsFlush !== 0) begin
            errors++; $display("FAIL first_block release cyc %0d spike %0d mask %0d flush %0d need 4 1 1 0", obsRelCyc, obsSpike, obsMask, obsFlush);
        end
        checks++;
        if (int'(o_loadCount) !== expLoad % CNT_MOD || int'(o_saveCount) !== expSave % CNT_MOD) begin
            errors++; $display("FAIL first_block counts got %0d/%0d need %0d/%0d", o_saveCount, o_loadCount, expSave % CNT_MOD, expLoad % CNT_MOD);
        end
    endtask

    task automatic test_next_block();
        run_op(2'b10, 16'h00F0, 1'b0, 15'h0101, 15'h0102, 2, 2, 0, 0);
        expSave++; expLoad++;
        checks++;
        if (obsPause !== 6 || obsW !== 2 || obsR !== 2 || obsAdrBad !== 0) begin
            errors++; $display("FAIL next_block pause/w/r/adrbad got %0d/%0d/%0d/%0d need 6/2/2/0", obsPause, obsW, obsR, obsAdrBad);
        end
        checks++;
        if (obsLastW >= obsFirstR || obsRelCyc !== 5 || obsImport !== 1) begin
            errors++; $display("FAIL next_block order lastW %0d firstR %0d rel %0d import %0d", obsLastW, obsFirstR, obsRelCyc, obsImport);
        end
        checks++;
        if (int'(o_saveCount) !== expSave % CNT_MOD || int'(o_loadCount) !== expLoad % CNT_MOD) begin
            errors++; $display("FAIL next_block counts got %0d/%0d need %0d/%0d", o_saveCount, o_loadCount, expSave % CNT_MOD, expLoad % CNT_MOD);
        end
    endtask

    task automatic test_noblend_skip();
        run_op(2'b10, 16'h0000, 1'b1, 15'h0055, 15'h0066, 1, 1, 0, 0);
        checks++;
        if (obsPause !== 2 || obsW !== 0 || obsR !== 0 || obsRelCyc !== 1 || obsImport !== 0) begin
            errors++; $display("FAIL noblend_skip pause %0d w %0d r %0d rel %0d imp %0d need 2 0 0 1 0", obsPause, obsW, obsR, obsRelCyc, obsImport);
        end
    endtask

    task automatic test_flush();
        run_op(2'b11, 16'hFFFF, 1'b0, 15'h7FFF, 15'h0001, 3, 1, 0, 0);
        expSave++;
        checks++;
        if (obsPause !== 5 || obsW !== 3 || obsR !== 0 || obsFlush !== 1 || obsFlushCyc !== 4) begin
            errors++; $display("FAIL flush_full pause %0d w %0d r %0d flush %0d at %0d need 5 3 0 1 4", obsPause, obsW, obsR, obsFlush, obsFlushCyc);
        end
        run_op(2'b11, 16'h0000, 1'b0, 15'h0002, 15'h0003, 1, 1, 0, 0);
        checks++;
        if (obsPause !== 2 || obsW !== 0 || obsR !== 0 || obsFlush !== 1 || obsFlushCyc !== 1) begin
            errors++; $display("FAIL flush_empty pause %0d w %0d r %0d flush %0d at %0d need 2 0 0 1 1", obsPause, obsW, obsR, obsFlush, obsFlushCyc);
        end
        checks++;
        if (int'(o_saveCount) !== expSave % CNT_MOD) begin
            errors++; $display("FAIL flush_count save got %0d need %0d", o_saveCount, expSave % CNT_MOD);
        end
    endtask

    task automatic test_reset_midsave();
        @(negedge clk);
        i_pairCode = 2'b11; i_mskBlock = 16'h8001; i_saveAdr = 15'h0333; i_noblend = 1'b0;
        i_blockOp = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (memIf.o_memWriteReq !== 1'b1) begin
            errors++; $display("FAIL midsave_req got %b need 1", memIf.o_memWriteReq);
        end
        #1;
        i_rst = 1'b1;
        i_blockOp = 1'b0;
        #1;
        checks++;
        if (all_outputs() !== 64'd0) begin
            errors++; $display("FAIL midsave_reset outputs got %h need 0", all_outputs());
        end
        expSave = 0; expLoad = 0;
        repeat (2) @(negedge clk);
        i_rst = 1'b0;
        @(negedge clk);
        memIf.i_memWriteAck = 1'b1;
        memIf.i_memReadAck  = 1'b1;
        #1;
        checks++;
        if (o_importBG !== 1'b0 || o_busy !== 1'b0) begin
            errors++; $display("FAIL post_reset_ack import %b busy %b need 0 0", o_importBG, o_busy);
        end
        @(negedge clk);
        memIf.i_memWriteAck = 1'b0;
        memIf.i_memReadAck  = 1'b0;
        #1;
        checks++;
        if (o_saveCount !== '0 || o_loadCount !== '0 || o_resetSpike !== 1'b0) begin
            errors++; $display("FAIL post_reset_count save %0d load %0d spike %b need 0 0 0", o_saveCount, o_loadCount, o_resetSpike);
        end
    endtask

    task automatic test_robust();
        @(negedge clk);
        memIf.i_memReadAck = 1'b1;
        memIf.i_memWriteAck = 1'b1;
        i_blockOp = 1'b1; i_pairCode = 2'b00;
        #1;
        checks++;
        if (o_importBG !== 1'b0 || o_pausePipeline !== 1'b0) begin
            errors++; $display("FAIL idle_stray import %b pause %b need 0 0", o_importBG, o_pausePipeline);
        end
        @(negedge clk);
        memIf.i_memReadAck = 1'b0;
        memIf.i_memWriteAck = 1'b0;
        i_blockOp = 1'b0;
        #1;
        checks++;
        if (o_busy !== 1'b0 || int'(o_saveCount) !== expSave % CNT_MOD || int'(o_loadCount) !== expLoad % CNT_MOD) begin
            errors++; $display("FAIL idle_stray_state busy %b save %0d load %0d", o_busy, o_saveCount, o_loadCount);
        end
        run_op(2'b10, 16'h0F0F, 1'b0, 15'h2468, 15'h1357, 4, 2, 1, 1);
        expSave++; expLoad++;
        checks++;
        if (obsAdrBad !== 0 || obsImport !== 1 || obsImportBad !== 0 || obsPause !== 8) begin
            errors++; $display("FAIL midsave_change adrbad %0d import %0d bad %0d pause %0d need 0 1 0 8", obsAdrBad, obsImport, obsImportBad, obsPause);
        end
        checks++;
        if (int'(o_loadCount) !== expLoad % CNT_MOD || int'(o_saveCount) !== expSave % CNT_MOD) begin
            errors++; $display("FAIL midsave_counts got %0d/%0d need %0d/%0d", o_saveCount, o_loadCount, expSave % CNT_MOD, expLoad % CNT_MOD);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            logic [1:0]  code = 2'($urandom_range(1, 3));
            logic [15:0] msk  = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            logic        nb   = 1'($urandom);
            logic [14:0] sa   = 15'($urandom);
            logic [14:0] la   = 15'($urandom);
            int          wl   = $urandom_range(1, 4);
            int          rl   = $urandom_range(1, 4);
            bit          es, el;
            int          ep;
            run_op(code, msk, nb, sa, la, wl, rl, 1'($urandom), 1'($urandom));
            es = mdl_save(code, msk);
            el = mdl_load(code, nb);
            if (es) expSave++;
            if (el) expLoad++;
            ep = 2 + (es ? wl : 0) + (el ? rl : 0);
            checks++;
            if (obsTimeout !== 0 || obsPause !== ep || obsRelCyc !== ep - 1) begin
                errors++; $display("FAIL rnd%0d pause got %0d rel %0d to %0d need %0d", n, obsPause, obsRelCyc, obsTimeout, ep);
            end
            checks++;
            if (obsW !== (es ? wl : 0) || obsR !== (el ? rl : 0) || obsAdrBad !== 0) begin
                errors++; $display("FAIL rnd%0d mem w %0d r %0d adrbad %0d need %0d %0d 0", n, obsW, obsR, obsAdrBad, es ? wl : 0, el ? rl : 0);
            end
            checks++;
            if (obsImport !== int'(el) || obsImportBad !== 0 || obsSpike !== 1 || obsMask !== 1 || obsFlush !== int'(code == 2'b11)) begin
                errors++; $display("FAIL rnd%0d pulses imp %0d spike %0d mask %0d flush %0d", n, obsImport, obsSpike, obsMask, obsFlush);
            end
            checks++;
            if (int'(o_saveCount) !== expSave % CNT_MOD || int'(o_loadCount) !== expLoad % CNT_MOD) begin
                errors++; $display("FAIL rnd%0d counts got %0d/%0d need %0d/%0d", n, o_saveCount, o_loadCount, expSave % CNT_MOD, expLoad % CNT_MOD);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            run_op(2'b11, 16'h0001, 1'b1, 15'(k), 15'd0, 1, 1, 0, 0);
        end
        checks++;
        if (o_saveCount !== 2'd1 || o_loadCount !== 2'd0) begin
            errors++; $display("FAIL wrap save %0d load %0d need 1 0", o_saveCount, o_loadCount);
        end
    endtask

    initial begin
        memIf.i_memWriteAck = 1'b0;
        memIf.i_memReadAck  = 1'b0;
        test_reset();
        test_first_block();
        test_next_block();
        test_noblend_skip();
        test_flush();
        test_reset_midsave();
        test_robust();
        test_random();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bg_block_mem_sched.md
Name: bg_block_mem_sched

Overview:
- Sequences background (BG) block traffic between the pixel backend's 16-pixel BG block register and the VRAM memory port.
- On each block-operation code from the backend it:
  - freezes the pixel pipeline,
  - saves the finished block (256-bit data plus 16-bit write mask) when any pixel was written,
  - loads the next block when blending needs it,
  - resets the backend's spike flag and pixel mask, then releases the pipeline.
- Also provides flush completion and save/load statistics counters.

Parameters:
- CNT_W, 16, width of the save and load statistics counters (wrap on overflow).

Ports:
- clk  in  1  system clock; all state on rising edge.
- i_rst  in  1  asynchronous active-high reset.
- i_blockOp  in  1  backend requests a block operation (level, held while paused).
- i_pairCode  in  2  00 none, 01 first block, 10 next block, 11 last block/flush.
- i_noblend  in  1  primitive does not blend; BG load is skipped.
- i_loadAdr  in  15  block address {y[8:0], x[9:4]} of the block to load.
- i_saveAdr  in  15  address of the last written block.
- i_mskBlock  in  16  per-pixel written mask of the current block.
- o_pausePipeline  out  1  freeze the backend pipeline.
- o_resetSpike  out  1  one-cycle pulse; clears the backend block-op flag.
- o_resetMask  out  1  one-cycle pulse; clears the backend pixel mask.
- o_importBG  out  1  one-cycle pulse; backend latches read data this cycle.
- o_memWriteReq  out  1  block write request (level until ack).
- o_memWriteAdr  out  15  latched save address.
- o_memWriteMsk  out  16  latched save mask.
- i_memWriteAck  in  1  one-cycle write acceptance.
- o_memReadReq  out  1  block read request (level until ack).
- o_memReadAdr  out  15  latched load address.
- i_memReadAck  in  1  one-cycle read data valid.
- o_flushDone  out  1  one-cycle pulse when a code-11 sequence completes.
- o_busy  out  1  state != IDLE.
- o_saveCount  out  CNT_W  number of completed saves.
- o_loadCount  out  CNT_W  number of completed loads.

Behaviour:
- Reset:
  - state forced to IDLE.
  - All outputs 0, latched addresses/mask 0, counters 0.
  - Any outstanding request drops immediately; acks arriving in the first cycle after reset are ignored.
- States: IDLE, SAVE, LOAD, RELEASE.
- o_pausePipeline:
  - Combinational = (state==IDLE & i_blockOp & i_pairCode!=00) | (state!=IDLE).
  - This ensures no pixel write occurs in the triggering cycle.
- IDLE:
  - Triggers on i_blockOp=1 with i_pairCode!=00.
  - On trigger, latch i_pairCode, i_saveAdr, i_mskBlock, i_loadAdr, i_noblend.
  - i_blockOp with code 00 is ignored.
- Transitions out of IDLE:
  - 01: LOAD if !noblend, else RELEASE.
  - 10 or 11, mask != 0: SAVE.
  - 10, mask == 0: LOAD if !noblend, else RELEASE.
  - 11, mask == 0: RELEASE.
- SAVE:
  - o_memWriteReq=1 with latched address/mask.
  - On i_memWriteAck: o_saveCount+1.
  - Next state: LOAD if code 10 & !noblend, else RELEASE.
  - An ack in the first SAVE cycle is accepted.
- LOAD:
  - o_memReadReq=1 with latched load address.
  - On i_memReadAck: o_importBG=1 that same cycle, o_loadCount+1, go to RELEASE.
- RELEASE (one cycle):
  - o_resetSpike=1, o_resetMask=1.
  - o_flushDone=1 if latched code is 11.
  - Next state IDLE; pause drops the following cycle.
- Handshake and input rules:
  - Acks outside their matching state are ignored.
  - A simultaneous write and read ack is impossible by construction; a read ack in SAVE is ignored.
  - i_blockOp and input changes while not IDLE are ignored; latched values are used.
- Timing:
  - Minimum pause is 2 cycles (trigger cycle plus RELEASE).
  - Save-then-load pause = 2 + write latency + read latency cycles.
- Counters wrap at 2^CNT_W.
- Reset mid-operation: abort without completing the save or load and without reset pulses.

Test Plan:
- Reset with o_memWriteReq active:
  - Drive i_rst high mid-SAVE.
  - Required: req drops asynchronously, all outputs 0, state IDLE, counters 0.
- First block, blending:
  - blockOp=1, code=01, noblend=0, loadAdr=0x1234; readAck after 3 cycles.
  - Required: pause from cycle 0, readReq with adr 0x1234, importBG pulses on the ack cycle.
  - Required: resetSpike/resetMask in the next cycle, pause low after that, loadCount=1.
- Next block, mask 0x00F0, saveAdr=0x0101, loadAdr=0x0102, noblend=0:
  - Required: writeReq with adr 0x0101, msk 0x00F0 until ack, then readReq 0x0102 until ack.
  - Required: RELEASE follows; saveCount=1, loadCount=1.
- Next block, mask 0x0000, noblend=1:
  - Required: no memory request, RELEASE one cycle after trigger, pause exactly 2 cycles.
- Flush, code 11, mask 0xFFFF:
  - Required: write only, no read; flushDone pulses once in RELEASE.
  - Flush with mask 0: flushDone pulses 1 cycle after trigger.
- Robustness and wrap:
  - Stray readAck in IDLE and SAVE, and an input change mid-SAVE.
  - Required: no importBG, latched address unchanged.
  - With CNT_W=2: the 5th save yields saveCount=1.
